// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, operand width, state type.
package calc_pkg;

    localparam int unsigned OPERAND_W = 7;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    typedef enum logic [1:0] {
        StNum1,
        StNum2,
        StExec,
        StDone
    } calc_state_e;

    // Codes 0-9 are decimal digits.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal digit accumulator: appends one digit to an operand, refusing results above max.
module calc_digit_acc (
    input  logic [6:0] cur,
    input  logic [3:0] digit,
    input  logic [6:0] max,
    output logic [6:0] next,
    output logic       ovf
);

    logic [10:0] cand;

    // Wide enough for 127*10+15, so the comparison never sees a wrapped value.
    always_comb begin
        cand = 11'(cur) * 11'd10 + 11'(digit);
        ovf  = cand > 11'(max);
        next = ovf ? cur : cand[6:0];
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for the two-operand add/sub calculator datapath.
// Optional idle auto-clear is enabled by defining CALC_TIMEOUT_EN.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned MAX_VAL        = 99,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [6:0] num1,
    output logic [6:0] num2,
    output logic       cal_mode,
    output logic       disp_mode,
    output logic       result_valid,
    output logic       key_reject
);

    calc_state_e state_q, state_d;
    logic [6:0]  num1_q, num1_d;
    logic [6:0]  num2_q, num2_d;
    logic        cal_mode_q, cal_mode_d;
    logic        disp_mode_q, disp_mode_d;
    logic        result_valid_q, result_valid_d;
    logic        key_reject_q, key_reject_d;

    logic        accept;
    logic        clear_req;
    logic        timeout_hit;
    logic [6:0]  acc_cur;
    logic [6:0]  acc_next;
    logic        acc_ovf;

    assign key_ready = (state_q != StExec);
    assign accept    = key_valid & key_ready;

    // One accumulator serves both operands; NUM2 is the only state that edits num2.
    assign acc_cur = (state_q == StNum2) ? num2_q : num1_q;

    calc_digit_acc u_digit_acc (
        .cur   (acc_cur),
        .digit (key_code),
        .max   (OPERAND_W'(MAX_VAL)),
        .next  (acc_next),
        .ovf   (acc_ovf)
    );

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    assign timeout_hit = (idle_cnt_q == CntLast) && (state_q != StExec);

    // Idle counter saturates at its terminal value so an EXEC cycle cannot wrap it.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (accept || timeout_hit) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CntLast) begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Key decode and next-state; clear_req folds clear key and timeout into one reset path.
    always_comb begin
        state_d        = state_q;
        num1_d         = num1_q;
        num2_d         = num2_q;
        cal_mode_d     = cal_mode_q;
        disp_mode_d    = disp_mode_q;
        result_valid_d = result_valid_q;
        key_reject_d   = 1'b0;
        clear_req      = 1'b0;

        unique case (state_q)
            StNum1: begin
                if (accept) begin
                    if (is_digit(key_code)) begin
                        if (acc_ovf) key_reject_d = 1'b1;
                        else         num1_d = acc_next;
                    end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                        cal_mode_d  = (key_code == KEY_PLUS);
                        num2_d      = '0;
                        disp_mode_d = 1'b1;
                        state_d     = StNum2;
                    end else if (key_code == KEY_CLR) begin
                        clear_req = 1'b1;
                    end else begin
                        key_reject_d = 1'b1;
                    end
                end
            end
            StNum2: begin
                if (accept) begin
                    if (is_digit(key_code)) begin
                        if (acc_ovf) key_reject_d = 1'b1;
                        else         num2_d = acc_next;
                    end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                        cal_mode_d = (key_code == KEY_PLUS);
                    end else if (key_code == KEY_EQ) begin
                        state_d = StExec;
                    end else if (key_code == KEY_CLR) begin
                        clear_req = 1'b1;
                    end else begin
                        key_reject_d = 1'b1;
                    end
                end
            end
            StExec: begin
                // Datapath settles during this cycle; the result is final from the next.
                state_d        = StDone;
                result_valid_d = 1'b1;
            end
            StDone: begin
                if (accept) begin
                    if (is_digit(key_code)) begin
                        num1_d         = {3'b000, key_code};
                        num2_d         = '0;
                        cal_mode_d     = 1'b1;
                        disp_mode_d    = 1'b0;
                        result_valid_d = 1'b0;
                        state_d        = StNum1;
                    end else if (key_code == KEY_CLR) begin
                        clear_req = 1'b1;
                    end else begin
                        key_reject_d = 1'b1;
                    end
                end
            end
            default: begin
                clear_req = 1'b1;
            end
        endcase

        if (timeout_hit) begin
            clear_req = 1'b1;
        end

        if (clear_req) begin
            state_d        = StNum1;
            num1_d         = '0;
            num2_d         = '0;
            cal_mode_d     = 1'b1;
            disp_mode_d    = 1'b0;
            result_valid_d = 1'b0;
            key_reject_d   = 1'b0;
        end
    end

    // State and output registers; reset wins over any key or pending EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StNum1;
            num1_q         <= '0;
            num2_q         <= '0;
            cal_mode_q     <= 1'b1;
            disp_mode_q    <= 1'b0;
            result_valid_q <= 1'b0;
            key_reject_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            num1_q         <= num1_d;
            num2_q         <= num2_d;
            cal_mode_q     <= cal_mode_d;
            disp_mode_q    <= disp_mode_d;
            result_valid_q <= result_valid_d;
            key_reject_q   <= key_reject_d;
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign cal_mode     = cal_mode_q;
    assign disp_mode    = disp_mode_q;
    assign result_valid = result_valid_q;
    assign key_reject   = key_reject_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed scenarios then random keys vs a model.
module tb_calc_key_sequencer;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [6:0] num1;
    logic [6:0] num2;
    logic       cal_mode;
    logic       disp_mode;
    logic       result_valid;
    logic       key_reject;

    calc_key_sequencer #(
        .MAX_VAL        (99),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .num1         (num1),
        .num2         (num2),
        .cal_mode     (cal_mode),
        .disp_mode    (disp_mode),
        .result_valid (result_valid),
        .key_reject   (key_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: calculator as a user would see it.
    int m_n1, m_n2;
    bit m_add, m_show2, m_result;
    bit m_second;    // user is typing the second operand
    bit m_answered;  // '=' has been pressed and answer is on screen

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input bit exp_rej, input bit exp_ready);
        check({tag, ".num1"}, int'(num1), m_n1);
        check({tag, ".num2"}, int'(num2), m_n2);
        check({tag, ".cal_mode"}, int'(cal_mode), int'(m_add));
        check({tag, ".disp_mode"}, int'(disp_mode), int'(m_show2));
        check({tag, ".result_valid"}, int'(result_valid), int'(m_result));
        check({tag, ".key_reject"}, int'(key_reject), int'(exp_rej));
        check({tag, ".key_ready"}, int'(key_ready), int'(exp_ready));
    endtask

    task automatic model_clear();
        m_n1 = 0; m_n2 = 0; m_add = 1; m_show2 = 0; m_result = 0;
        m_second = 0; m_answered = 0;
    endtask

    // Applies one accepted key to the model; reports rejection and whether '=' fired.
    task automatic model_key(input int k, output bit rej, output bit eq);
        rej = 0; eq = 0;
        if (k == 13) begin
            model_clear();
        end else if (k >= 14) begin
            rej = 1;
        end else if (m_answered) begin
            if (k <= 9) begin
                m_n1 = k; m_n2 = 0; m_add = 1; m_show2 = 0; m_result = 0;
                m_answered = 0;
            end else begin
                rej = 1;
            end
        end else if (k <= 9) begin
            if (m_second) begin
                if (m_n2 * 10 + k <= 99) m_n2 = m_n2 * 10 + k; else rej = 1;
            end else begin
                if (m_n1 * 10 + k <= 99) m_n1 = m_n1 * 10 + k; else rej = 1;
            end
        end else if (k == 10 || k == 11) begin
            m_add = (k == 10);
            if (!m_second) begin
                m_n2 = 0; m_show2 = 1; m_second = 1;
            end
        end else begin
            if (m_second) begin
                eq = 1; m_second = 0; m_answered = 1;
            end else begin
                rej = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presses one key for one cycle and checks the outcome, including the EXEC bubble.
    task automatic press(input string tag, input int k);
        bit rej, eq;
        check({tag, ".ready_before"}, int'(key_ready), 1);
        key_valid = 1'b1;
        key_code  = 4'(k);
        model_key(k, rej, eq);
        tick();
        key_valid = 1'b0;
        check_all(tag, rej, !eq);
        if (eq) begin
            tick();
            m_result = 1;
            check_all({tag, ".done"}, 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        check_all("reset", 1'b0, 1'b1);

        // 42 + 17 =
        press("t1_4", 4); press("t1_2", 2); press("t1_plus", 10);
        press("t1_1", 1); press("t1_7", 7); press("t1_eq", 12);
        check("t1.num1", int'(num1), 42);
        check("t1.num2", int'(num2), 17);

        // Overflow of the third digit
        do_reset();
        press("t2_9a", 9); press("t2_9b", 9); press("t2_5", 5);
        check("t2.num1", int'(num1), 99);
        tick();
        check("t2.reject_cleared", int'(key_reject), 0);

        // Operator overwrite
        do_reset();
        press("t3_5", 5); press("t3_plus", 10); press("t3_minus", 11);
        press("t3_3", 3); press("t3_eq", 12);
        check("t3.cal_mode", int'(cal_mode), 0);

        // From DONE: operator rejected, digit restarts
        press("t4_plus", 10); press("t4_7", 7);
        check("t4.num1", int'(num1), 7);

        // Reserved codes and '=' in NUM1
        press("res14", 14); press("res15", 15); press("eq_in_num1", 12);

        // Reset together with '=' in NUM2
        press("t5_plus", 11); press("t5_8", 8);
        rst_n     = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'd12;
        tick();
        key_valid = 1'b0;
        rst_n     = 1'b1;
        model_clear();
        check_all("t5.reset", 1'b0, 1'b1);
        tick();
        check_all("t5.no_exec", 1'b0, 1'b1);

        // Idle auto-clear
        press("t6_3", 3);
        for (int i = 0; i < 15; i++) tick();
        check("t6.before", int'(num1), 3);
        tick();
`ifdef CALC_TIMEOUT_EN
        check("t6.cleared", int'(num1), 0);
        model_clear();
`else
        for (int i = 0; i < 30; i++) tick();
        check("t6.held", int'(num1), 3);
`endif

        // Random keys, short idle gaps (well below the idle limit)
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int k;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = int'($urandom_range(0, 9));
            else if (r < 97) k = int'($urandom_range(10, 12));
            else             k = int'($urandom_range(13, 15));
            press($sformatf("rnd%0d", i), k);
            r = int'($urandom_range(0, 3));
            for (int g = 0; g < r; g++) begin
                tick();
                check_all($sformatf("gap%0d", i), 1'b0, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
